// File: rtl/pipe_pkg.sv
// Shared defaults and the tag record carried alongside each op in flight.
package pipe_pkg;

    localparam int unsigned DefN   = 4;
    localparam int unsigned DefW   = 10;
    localparam int unsigned DefLat = 4;

    // Fixed id width covers the largest supported requester count (8).
    localparam int unsigned TagIdw = 3;

    typedef struct packed {
        logic              valid;
        logic [TagIdw-1:0] id;
    } tag_t;

endpackage

// File: rtl/pipe_sched_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           grant_valid
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = IDW'((32'(ptr) + off) % N);
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_sched.sv
// Round-robin scheduler feeding one shared LAT-stage datapath and routing results back by tag.
module pipe_sched
    import pipe_pkg::*;
#(
    parameter int unsigned N   = DefN,
    parameter int unsigned W   = DefW,
    parameter int unsigned LAT = DefLat,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    input  logic [N*W-1:0] c_in,
    input  logic [N*W-1:0] d_in,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   pipe_a,
    output logic [W-1:0]   pipe_b,
    output logic [W-1:0]   pipe_c,
    output logic [W-1:0]   pipe_d,
    input  logic [W-1:0]   pipe_f,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           busy
);

    // Stage 0 rides with pipe_*; stages 1..LAT follow the datapath stages, so the
    // last stage is valid exactly while pipe_f carries that op's result.
    localparam int unsigned TagDepth = LAT + 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   outstanding_q, outstanding_d;
    logic [N-1:0]   ack_q;
    logic [W-1:0]   pipe_a_q, pipe_b_q, pipe_c_q, pipe_d_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_data_q;
    logic           busy_q;
    tag_t           tags_q [TagDepth];

    logic [N-1:0]   eligible;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_valid;
    logic           issue;
    logic [N-1:0]   rsp_clear;
    tag_t           tag_in;
    tag_t           tag_last;
    logic [W-1:0]   sel_a, sel_b, sel_c, sel_d;

    assign eligible = req & ~outstanding_q;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .eligible    (eligible),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign issue    = en & grant_valid;
    assign tag_last = tags_q[TagDepth-1];

    always_comb begin
        sel_a = a_in[32'(grant_idx)*W +: W];
        sel_b = b_in[32'(grant_idx)*W +: W];
        sel_c = c_in[32'(grant_idx)*W +: W];
        sel_d = d_in[32'(grant_idx)*W +: W];
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.id    = TagIdw'(grant_idx);
    end

    always_comb begin
        rsp_clear = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rsp_clear[i] = tag_last.valid && (tag_last.id == TagIdw'(i));
        end
    end

    always_comb begin
        outstanding_d = outstanding_q & ~rsp_clear;
        ptr_d         = ptr_q;
        if (issue) begin
            outstanding_d = outstanding_d | grant;
            ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            outstanding_q <= '0;
            ack_q         <= '0;
            pipe_a_q      <= '0;
            pipe_b_q      <= '0;
            pipe_c_q      <= '0;
            pipe_d_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            for (int unsigned k = 0; k < TagDepth; k++) begin
                tags_q[k] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            outstanding_q <= outstanding_d;
            busy_q        <= |outstanding_d;
            ack_q         <= issue ? grant : '0;
            if (issue) begin
                pipe_a_q <= sel_a;
                pipe_b_q <= sel_b;
                pipe_c_q <= sel_c;
                pipe_d_q <= sel_d;
            end
            tags_q[0] <= tag_in;
            for (int unsigned k = 1; k < TagDepth; k++) begin
                tags_q[k] <= tags_q[k-1];
            end
            rsp_valid_q <= tag_last.valid;
            if (tag_last.valid) begin
                rsp_id_q   <= IDW'(tag_last.id);
                rsp_data_q <= pipe_f;
            end
        end
    end

    assign ack       = ack_q;
    assign pipe_a    = pipe_a_q;
    assign pipe_b    = pipe_b_q;
    assign pipe_c    = pipe_c_q;
    assign pipe_d    = pipe_d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Randomized scoreboard bench for pipe_sched with a behavioural datapath and arbitration model.
module tb_pipe_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 10;
    localparam int unsigned LAT = 4;
    localparam int unsigned IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in, c_in, d_in;
    logic [N-1:0]   ack;
    logic [W-1:0]   pipe_a, pipe_b, pipe_c, pipe_d, pipe_f;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    pipe_sched #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .ack       (ack),
        .pipe_a    (pipe_a),
        .pipe_b    (pipe_b),
        .pipe_c    (pipe_c),
        .pipe_d    (pipe_d),
        .pipe_f    (pipe_f),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [W-1:0] fref(logic [W-1:0] a, logic [W-1:0] b,
                                          logic [W-1:0] c, logic [W-1:0] d);
        logic [W-1:0]   s;
        logic [2*W-1:0] p;
        s = (a + b) + (c - d);
        p = s * d;
        return p[W-1:0];
    endfunction

    // Shared datapath: LAT registers, no reset.
    logic [W-1:0] dp [LAT];
    always @(posedge clk) begin
        dp[0] <= fref(pipe_a, pipe_b, pipe_c, pipe_d);
        for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
    end
    assign pipe_f = dp[LAT-1];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference state: remaining cycles until each requester is eligible again.
    int   rem [N];
    int   ptr_m;
    logic hold_all;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), mon_e.id);
                    chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    chk("rsp_cycle", cycle, mon_e.due);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cycle) begin
                chk("rsp_missing", 32'(rsp_valid), 1);
                mon_e = exp_q.pop_front();
            end
        end
    end

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b,
                           logic [W-1:0] c, logic [W-1:0] d);
        req[i] = 1'b1;
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        c_in[i*W +: W] = c;
        d_in[i*W +: W] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        ptr_m = 0;
        exp_q.delete();
    endtask

    task automatic do_cycle();
        int           g;
        int           idx;
        logic [W-1:0] ga, gb, gc, gd;
        logic [N-1:0] exp_ack;
        logic         busy_exp;
        exp_t         e;
        g = -1;
        ga = '0; gb = '0; gc = '0; gd = '0;
        if (en) begin
            for (int off = 0; off < N; off++) begin
                idx = (ptr_m + off) % N;
                if (g < 0 && req[idx] && rem[idx] == 0) g = idx;
            end
        end
        exp_ack = '0;
        if (g >= 0) begin
            exp_ack[g] = 1'b1;
            ga = a_in[g*W +: W];
            gb = b_in[g*W +: W];
            gc = c_in[g*W +: W];
            gd = d_in[g*W +: W];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (rem[i] > 0) rem[i]--;
        if (g >= 0) begin
            rem[g] = LAT + 1;
            ptr_m  = (g + 1) % N;
            e.id   = g;
            e.data = fref(ga, gb, gc, gd);
            e.due  = cycle + LAT + 1;
            exp_q.push_back(e);
            chk("pipe_a", 32'(pipe_a), 32'(ga));
            chk("pipe_b", 32'(pipe_b), 32'(gb));
            chk("pipe_c", 32'(pipe_c), 32'(gc));
            chk("pipe_d", 32'(pipe_d), 32'(gd));
        end
        chk("ack", 32'(ack), 32'(exp_ack));
        busy_exp = 1'b0;
        for (int i = 0; i < N; i++) if (rem[i] != 0) busy_exp = 1'b1;
        chk("busy", 32'(busy), 32'(busy_exp));
        for (int i = 0; i < N; i++) if (ack[i] && !hold_all) req[i] = 1'b0;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) do_cycle();
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_pipe_a"}, 32'(pipe_a), 0);
        chk({tag, "_pipe_d"}, 32'(pipe_d), 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = '0; hold_all = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Single op, then a wrapping op.
        set_req(0, 10'd3, 10'd4, 10'd10, 10'd2);
        run(LAT + 4);
        set_req(1, 10'd1000, 10'd23, 10'd0, 10'd1);
        run(LAT + 4);

        // All requesters held high: rotation and no early re-grant.
        hold_all = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 10'(i + 1), 10'(7 * i), 10'(100 + i), 10'(i + 2));
        run(16);
        hold_all = 1'b0;
        req = '0;
        run(LAT + 3);

        // Pointer at 2, then requesters 0, 1 and 3.
        set_req(1, 10'd5, 10'd6, 10'd7, 10'd8);
        run(LAT + 3);
        set_req(0, 10'd11, 10'd12, 10'd13, 10'd14);
        set_req(1, 10'd21, 10'd22, 10'd23, 10'd24);
        set_req(3, 10'd31, 10'd32, 10'd33, 10'd34);
        run(LAT + 6);

        // Issue disabled while requester 2 waits and an op drains.
        set_req(0, 10'd9, 10'd9, 10'd1, 10'd3);
        do_cycle();
        set_req(2, 10'd40, 10'd50, 10'd60, 10'd70);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(LAT + 4);

        // Asynchronous reset with three ops in flight.
        set_req(0, 10'd1, 10'd2, 10'd3, 10'd4);
        set_req(1, 10'd5, 10'd6, 10'd7, 10'd8);
        set_req(2, 10'd9, 10'd10, 10'd11, 10'd12);
        run(3);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(LAT + 3);
        set_req(1, 10'd100, 10'd200, 10'd300, 10'd5);
        set_req(3, 10'd17, 10'd18, 10'd19, 10'd20);
        do_cycle();
        set_req(0, 10'd3, 10'd4, 10'd10, 10'd2);
        run(LAT + 6);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
                end
            end
            do_cycle();
        end
        en = 1'b1;
        run(2 * (LAT + 2));
        req = '0;
        run(2 * (LAT + 2));
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
